multicycle_controller: RTL and testbench



---
 rtl/multicycle_controller.sv | 216 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Control unit for the multicycle MIPS datapath. A single Moore FSM
//   sequences fetch, decode, execute, memory and writeback over the shared
//   memory, ALU and register file.
//
// Ports
//   clk         in   system clock, rising-edge
//   reset       in   asynchronous active-high reset, forces FETCH
//   op          in   opcode instr[31:26]
//   funct       in   function field instr[5:0]
//   zero        in   ALU zero flag
//   pcen        out  PC enable (pcwrite, or branch & zero)
//   memwrite    out  memory write strobe
//   irwrite     out  instruction register enable
//   regwrite    out  register file write enable
//   alusrca     out  ALU A select: 0 = PC, 1 = register A
//   iord        out  memory address select: 0 = PC, 1 = ALUOut
//   memtoreg    out  writeback select: 0 = ALUOut, 1 = memory data
//   regdst      out  destination select: 0 = rt, 1 = rd
//   alusrcb     out  ALU B select: B / 4 / imm / imm<<2
//   pcsrc       out  PC source: ALU result / ALUOut / jump target
//   alucontrol  out  ALU operation
//   illegal     out  unsupported opcode (DECODE) or funct (EXECUTE)
//
// Outputs are decoded combinationally from the state register so that an
// asynchronous reset removes memwrite/regwrite in the same instant.
module multicycle_controller #(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] op,
  input  logic [OPW-1:0] funct,
  input  logic           zero,
  output logic           pcen,
  output logic           memwrite,
  output logic           irwrite,
  output logic           regwrite,
  output logic           alusrca,
  output logic           iord,
  output logic           memtoreg,
  output logic           regdst,
  output logic [1:0]     alusrcb,
  output logic [1:0]     pcsrc,
  output logic [2:0]     alucontrol,
  output logic           illegal
);

  localparam logic [OPW-1:0] OP_LW    = 6'b100011;
  localparam logic [OPW-1:0] OP_SW    = 6'b101011;
  localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPW-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OPW-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OPW-1:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [1:0] aluop_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       op_bad_s;
  logic       funct_bad_s;

  // State register with asynchronous return to FETCH
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_next_s = FETCH;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    iord         = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop_s      = 2'b00;
    pcwrite_s    = 1'b0;
    branch_s     = 1'b0;
    op_bad_s     = 1'b0;
    case (state_r)
      FETCH: begin
        alusrcb      = 2'b01;
        irwrite      = 1'b1;
        pcwrite_s    = 1'b1;
        state_next_s = DECODE;
      end
      DECODE: begin
        // Branch target is computed speculatively into ALUOut here
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next_s = MEMADR;
          OP_RTYPE:     state_next_s = EXECUTE;
          OP_BEQ:       state_next_s = BRANCH;
          OP_ADDI:      state_next_s = ADDIEX;
          OP_J:         state_next_s = JUMP;
          default: begin
            state_next_s = FETCH;
            op_bad_s     = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_LW) begin
          state_next_s = MEMREAD;
        end else if (op == OP_SW) begin
          state_next_s = MEMWRITE;
        end else begin
          state_next_s = FETCH;
        end
      end
      MEMREAD: begin
        iord         = 1'b1;
        state_next_s = MEMWB;
      end
      MEMWB: begin
        memtoreg     = 1'b1;
        regwrite     = 1'b1;
        state_next_s = FETCH;
      end
      MEMWRITE: begin
        iord         = 1'b1;
        memwrite     = 1'b1;
        state_next_s = FETCH;
      end
      EXECUTE: begin
        alusrca      = 1'b1;
        aluop_s      = 2'b10;
        state_next_s = ALUWB;
      end
      ALUWB: begin
        regdst       = 1'b1;
        regwrite     = 1'b1;
        state_next_s = FETCH;
      end
      BRANCH: begin
        alusrca      = 1'b1;
        aluop_s      = 2'b01;
        pcsrc        = 2'b01;
        branch_s     = 1'b1;
        state_next_s = FETCH;
      end
      ADDIEX: begin
        alusrca      = 1'b1;
        alusrcb      = 2'b10;
        state_next_s = ADDIWB;
      end
      ADDIWB: begin
        regwrite     = 1'b1;
        state_next_s = FETCH;
      end
      JUMP: begin
        pcsrc        = 2'b10;
        pcwrite_s    = 1'b1;
        state_next_s = FETCH;
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  // ALU operation decode; funct only matters when aluop selects it
  always_comb begin
    alucontrol  = 3'b010;
    funct_bad_s = 1'b0;
    case (aluop_s)
      2'b00: alucontrol = 3'b010;
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100000: alucontrol = 3'b010;
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default: begin
            alucontrol  = 3'b010;
            funct_bad_s = 1'b1;
          end
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // zero only reaches pcen through the branch path
  assign pcen    = pcwrite_s | (branch_s & zero);
  assign illegal = op_bad_s | funct_bad_s;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller
//   Directed bench for multicycle_controller. The controller state is
//   observed through its output signature; each sample is taken on the
//   falling edge and compared against hand-written per-state values.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       illegal;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.OPW(6)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .alusrca(alusrca), .iord(iord), .memtoreg(memtoreg), .regdst(regdst),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal)
  );

  // Output signature, MSB first:
  // pcen memwrite irwrite regwrite alusrca iord memtoreg regdst alusrcb pcsrc alucontrol illegal
  logic [15:0] obs_s;
  assign obs_s = {pcen, memwrite, irwrite, regwrite, alusrca, iord, memtoreg, regdst,
                  alusrcb, pcsrc, alucontrol, illegal};

  function automatic logic [15:0] ov(input logic pe, input logic mw, input logic ir,
                                     input logic rw, input logic sa, input logic io,
                                     input logic mr, input logic rd, input logic [1:0] sb,
                                     input logic [1:0] ps, input logic [2:0] alu,
                                     input logic ill);
    return {pe, mw, ir, rw, sa, io, mr, rd, sb, ps, alu, ill};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [15:0] exp);
    @(negedge clk);
    check_val(tag, obs_s, exp);
  endtask

  task automatic start(input logic [5:0] o, input logic [5:0] f, input logic z);
    op    = o;
    funct = f;
    zero  = z;
  endtask

  logic [15:0] e_fetch, e_decode, e_decode_ill, e_memadr, e_memread, e_memwb, e_memwrite;
  logic [15:0] e_aluwb, e_addiex, e_addiwb, e_jump;

  logic [5:0] fn_tab  [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
  logic [2:0] alu_tab [6] = '{3'b010,    3'b110,    3'b000,    3'b001,    3'b111,    3'b010};
  logic       ill_tab [6] = '{1'b0,      1'b0,      1'b0,      1'b0,      1'b0,      1'b1};

  initial begin
    e_fetch      = ov(1,0,1,0, 0,0,0,0, 2'b01, 2'b00, 3'b010, 0);
    e_decode     = ov(0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 3'b010, 0);
    e_decode_ill = ov(0,0,0,0, 0,0,0,0, 2'b11, 2'b00, 3'b010, 1);
    e_memadr     = ov(0,0,0,0, 1,0,0,0, 2'b10, 2'b00, 3'b010, 0);
    e_memread    = ov(0,0,0,0, 0,1,0,0, 2'b00, 2'b00, 3'b010, 0);
    e_memwb      = ov(0,0,0,1, 0,0,1,0, 2'b00, 2'b00, 3'b010, 0);
    e_memwrite   = ov(0,1,0,0, 0,1,0,0, 2'b00, 2'b00, 3'b010, 0);
    e_aluwb      = ov(0,0,0,1, 0,0,0,1, 2'b00, 2'b00, 3'b010, 0);
    e_addiex     = ov(0,0,0,0, 1,0,0,0, 2'b10, 2'b00, 3'b010, 0);
    e_addiwb     = ov(0,0,0,1, 0,0,0,0, 2'b00, 2'b00, 3'b010, 0);
    e_jump       = ov(1,0,0,0, 0,0,0,0, 2'b00, 2'b10, 3'b010, 0);

    // Reset held for 22 ns; outputs sit at FETCH values throughout
    reset = 1'b1;
    start(6'b100011, 6'b000000, 1'b1);
    step("rst_a", e_fetch);
    step("rst_b", e_fetch);
    #2 reset = 1'b0;
    #1 check_val("fetch0", obs_s, e_fetch);

    // lw with zero held high: zero must not leak into pcen outside BRANCH
    step("lw_decode",  e_decode);
    step("lw_memadr",  e_memadr);
    step("lw_memread", e_memread);
    step("lw_memwb",   e_memwb);
    step("lw_fetch",   e_fetch);

    // sw
    start(6'b101011, 6'b000000, 1'b0);
    step("sw_decode",   e_decode);
    step("sw_memadr",   e_memadr);
    step("sw_memwrite", e_memwrite);
    step("sw_fetch",    e_fetch);

    // beq taken
    start(6'b000100, 6'b000000, 1'b1);
    step("beqt_decode", e_decode);
    step("beqt_branch", ov(1,0,0,0, 1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
    step("beqt_fetch",  e_fetch);

    // beq not taken, then zero raised mid-cycle reaches pcen at once
    start(6'b000100, 6'b000000, 1'b0);
    step("beqn_decode", e_decode);
    step("beqn_branch", ov(0,0,0,0, 1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
    zero = 1'b1;
    #1 check_val("beq_zero_comb", obs_s, ov(1,0,0,0, 1,0,0,0, 2'b00, 2'b01, 3'b110, 0));
    zero = 1'b0;
    step("beqn_fetch", e_fetch);

    // R-type funct sweep, last entry is an unsupported funct
    for (int i = 0; i < 6; i++) begin
      start(6'b000000, fn_tab[i], 1'b0);
      step("r_decode", e_decode);
      step("r_execute", ov(0,0,0,0, 1,0,0,0, 2'b00, 2'b00, alu_tab[i], ill_tab[i]));
      step("r_aluwb",  e_aluwb);
      step("r_fetch",  e_fetch);
    end

    // addi
    start(6'b001000, 6'b000000, 1'b0);
    step("addi_decode", e_decode);
    step("addi_ex",     e_addiex);
    step("addi_wb",     e_addiwb);
    step("addi_fetch",  e_fetch);

    // j
    start(6'b000010, 6'b000000, 1'b0);
    step("j_decode", e_decode);
    step("j_jump",   e_jump);
    step("j_fetch",  e_fetch);

    // Unsupported opcodes return to FETCH straight from DECODE
    start(6'b111111, 6'b000000, 1'b0);
    step("ill_decode", e_decode_ill);
    step("ill_fetch",  e_fetch);
    start(6'b000011, 6'b100000, 1'b0);
    step("ill2_decode", e_decode_ill);
    step("ill2_fetch",  e_fetch);

    // Reset during MEMWRITE drops memwrite without waiting for a clock
    start(6'b101011, 6'b000000, 1'b0);
    step("swr_decode",   e_decode);
    step("swr_memadr",   e_memadr);
    step("swr_memwrite", e_memwrite);
    #1 reset = 1'b1;
    #1 check_val("rst_async", obs_s, e_fetch);
    step("rst_hold", e_fetch);
    reset = 1'b0;
    #1 check_val("rst_release", obs_s, e_fetch);

    // Normal sequencing resumes on the first edge after release
    start(6'b000010, 6'b000000, 1'b0);
    step("j2_decode", e_decode);
    step("j2_jump",   e_jump);
    step("j2_fetch",  e_fetch);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
